fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 32, sample width on every stream.
REQ-002 SHALL have parameter MAX_LOG2, 10, largest supported log2 FFT length (1024 points).
REQ-003 SHALL have port I_CLOCK  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port I_RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have port I_ENABLE  in  1  permit new frames to start.
REQ-006 SHALL have port I_NFFT_LOG2  in  4  requested log2 frame length.
REQ-007 SHALL have port I_FWD_INV  in  1  requested direction: 1 = forward, 0 = inverse.
REQ-008 SHALL have ports S_I_DATA_VALID in 1, S_O_DATA_READY out 1, S_I_DATA in DATA_W, S_I_DATA_TLAST in 1: upstream sample stream.
REQ-009 SHALL have ports F_O_DATA_VALID out 1, F_I_DATA_READY in 1, F_O_DATA out DATA_W, F_O_DATA_TLAST out 1: FFT data input stream.
REQ-010 SHALL have ports F_O_CFG_VALID out 1, F_I_CFG_READY in 1, F_O_CFG_DATA out 16: FFT config stream.
REQ-011 SHALL have ports O_FRAME_CNT out 16 (frames completed), O_ERR_TLAST out 1 (sticky upstream TLAST mismatch), O_BUSY out 1 (frame in progress).

Function
REQ-012 SHALL implement the FSM CFG -> WAIT -> RUN -> WAIT; reset enters CFG.
REQ-013 CFG: F_O_CFG_VALID=1 and F_O_CFG_DATA={7'b0, fwd_inv_l, 4'b0, nfft_l}; on VALID&READY go to WAIT. F_O_CFG_DATA SHALL stay stable while VALID is high.
REQ-014 nfft_l/fwd_inv_l SHALL be latched on entry to CFG, with I_NFFT_LOG2 clamped to [3, MAX_LOG2].
REQ-015 WAIT: if the clamped I_NFFT_LOG2 or I_FWD_INV differs from the latched value, go to CFG; else if I_ENABLE=1, go to RUN with the sample counter cleared.
REQ-016 RUN: the data path SHALL be combinational pass-through with zero latency: F_O_DATA=S_I_DATA, F_O_DATA_VALID=S_I_DATA_VALID, S_O_DATA_READY=F_I_DATA_READY.
REQ-017 Outside RUN: F_O_DATA_VALID=0 and S_O_DATA_READY=0.
REQ-018 The sample counter SHALL increment on each F_O_DATA_VALID&F_I_DATA_READY.
REQ-019 F_O_DATA_TLAST SHALL be 1 exactly when the counter equals 2^nfft_l-1; this is generated internally and never copied from upstream.
REQ-020 The last-sample handshake SHALL increment O_FRAME_CNT (wrapping at 16 bits) and return the FSM to WAIT.
REQ-021 I_ENABLE deassertion or a config change mid-frame SHALL NOT truncate the frame; both take effect in WAIT.
REQ-022 O_ERR_TLAST SHALL set when a handshake has S_I_DATA_TLAST different from the generated F_O_DATA_TLAST, and clear only on reset.
REQ-023 O_BUSY SHALL be 1 in RUN only.
REQ-024 At most one config transaction SHALL be issued per WAIT visit; no data SHALL pass between config issue and config acceptance.

Reset
REQ-025 Reset SHALL set state=CFG, counter=0, O_FRAME_CNT=0, O_ERR_TLAST=0, O_BUSY=0, F_O_CFG_VALID=0 in the reset cycle, and F_O_DATA_VALID=0.
REQ-026 Reset mid-frame SHALL abandon the frame without asserting TLAST; a fresh config SHALL be issued after release.

Configuration
REQ-027 Macro FFT_CTRL_EVENT_EN, when defined, SHALL add ports F_I_EV_TLAST_UNEXPECTED in 1, F_I_EV_TLAST_MISSING in 1 and O_ERR_FFT out 1.
REQ-028 With the macro defined, O_ERR_FFT SHALL be sticky: it sets on either event pulse and clears on reset only.
REQ-029 With the macro undefined, those ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-030 The FSM state encoding, CFG_W=16, MIN_LOG2=3 and the config-word field offsets SHALL live in shared package fft_ctrl_pkg.
REQ-031 Frame length and TLAST generation SHALL be in one sub-module, fft_frame_counter.
REQ-032 The FSM, config channel and error flags SHALL reside in fft_frame_ctrl.

Verification
REQ-033 Case: reset, then I_NFFT_LOG2=3, I_FWD_INV=1, CFG_READY=1.
  - F_O_CFG_DATA SHALL be 0x0103, accepted once.
  - 8 samples SHALL pass with TLAST on the 8th, and O_FRAME_CNT SHALL be 1.
REQ-034 Case: I_NFFT_LOG2=15 with MAX_LOG2=10.
  - Config nfft field SHALL be 10.
  - The frame SHALL be 1024 samples.
  - I_NFFT_LOG2=1 SHALL yield nfft field 3.
REQ-035 Case: change I_NFFT_LOG2 from 4 to 5 after sample 6 of a 16-sample frame.
  - The frame SHALL complete at 16 with TLAST.
  - A new config 0x0105 SHALL be issued.
  - The next frame SHALL be 32 samples.
REQ-036 Case: random F_I_DATA_READY/S_I_DATA_VALID stalls.
  - Data SHALL match 1:1.
  - TLAST SHALL fall on every 2^n-th handshake.
  - No data SHALL transfer while F_O_CFG_VALID=1 with F_I_CFG_READY held 0 for 20 cycles.
REQ-037 Case: upstream TLAST on sample 5 of 8.
  - O_ERR_TLAST SHALL set and stay set.
  - The frame SHALL still end at 8.
REQ-038 Case: I_RESET asserted at sample 3.
  - All outputs SHALL reach reset values next cycle.
  - After release, the config SHALL be reissued.
  - With FFT_CTRL_EVENT_EN defined, a 1-cycle F_I_EV_TLAST_MISSING pulse SHALL hold O_ERR_FFT=1.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller: FSM encoding, config-word layout
// and the frame-length clamp.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_CFG  = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } ctrl_state_t;

    localparam int unsigned CFG_W        = 16;
    localparam int unsigned MIN_LOG2     = 3;
    localparam int unsigned CFG_NFFT_LSB = 0;
    localparam int unsigned CFG_NFFT_W   = 4;
    localparam int unsigned CFG_DIR_BIT  = 8;

    function automatic logic [3:0] clamp_log2(input logic [3:0] req, input logic [3:0] max_log2);
        if (req < 4'(MIN_LOG2))
            return 4'(MIN_LOG2);
        if (req > max_log2)
            return max_log2;
        return req;
    endfunction

    function automatic logic [CFG_W-1:0] pack_cfg(input logic [3:0] nfft, input logic fwd_inv);
        logic [CFG_W-1:0] w;
        w = '0;
        w[CFG_NFFT_LSB +: CFG_NFFT_W] = nfft;
        w[CFG_DIR_BIT] = fwd_inv;
        return w;
    endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Sample counter for one FFT frame: counts accepted samples and flags the last one
// of a 2^nfft_log2 frame.
module fft_frame_counter #(
    parameter int unsigned MAX_LOG2 = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    input  logic [3:0] nfft_log2,
    output logic       tlast
);

    localparam logic [MAX_LOG2:0] ONE = (MAX_LOG2+1)'(1);

    logic [MAX_LOG2-1:0] count;
    logic [MAX_LOG2:0]   last_idx;

    always_comb begin
        last_idx = (ONE << nfft_log2) - ONE;
        tlast    = ({1'b0, count} == last_idx);
    end

    // Wrapping to zero on the last sample keeps TLAST low while the FSM idles.
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (advance) begin
            if (tlast)
                count <= '0;
            else
                count <= count + MAX_LOG2'(1);
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// FFT frame controller: issues the FFT config word, gates upstream samples into
// whole frames with generated TLAST. Optional macro: FFT_CTRL_EVENT_EN (FFT event flag).
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOG2 = 10
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET,
    input  logic              I_ENABLE,
    input  logic [3:0]        I_NFFT_LOG2,
    input  logic              I_FWD_INV,
    input  logic              S_I_DATA_VALID,
    output logic              S_O_DATA_READY,
    input  logic [DATA_W-1:0] S_I_DATA,
    input  logic              S_I_DATA_TLAST,
    output logic              F_O_DATA_VALID,
    input  logic              F_I_DATA_READY,
    output logic [DATA_W-1:0] F_O_DATA,
    output logic              F_O_DATA_TLAST,
    output logic              F_O_CFG_VALID,
    input  logic              F_I_CFG_READY,
    output logic [CFG_W-1:0]  F_O_CFG_DATA,
    output logic [15:0]       O_FRAME_CNT,
    output logic              O_ERR_TLAST,
`ifdef FFT_CTRL_EVENT_EN
    input  logic              F_I_EV_TLAST_UNEXPECTED,
    input  logic              F_I_EV_TLAST_MISSING,
    output logic              O_ERR_FFT,
`endif
    output logic              O_BUSY
);

    localparam logic [3:0] MAX_L = 4'(MAX_LOG2);

    ctrl_state_t state, next_state;
    logic [3:0]  nfft_l;
    logic        fwd_inv_l;
    logic        cfg_pending;
    logic [3:0]  req_nfft;
    logic        cfg_changed;
    logic        cfg_hs;
    logic        data_hs;
    logic        last_hs;
    logic        load_cfg;
    logic        cnt_clear;
    logic        tlast;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET)
            state <= ST_CFG;
        else
            state <= next_state;
    end

    always_comb begin
        req_nfft    = clamp_log2(I_NFFT_LOG2, MAX_L);
        cfg_changed = (req_nfft != nfft_l) || (I_FWD_INV != fwd_inv_l);
        next_state  = state;
        case (state)
            ST_CFG:  if (cfg_hs) next_state = ST_WAIT;
            ST_WAIT: begin
                if (cfg_changed)
                    next_state = ST_CFG;
                else if (I_ENABLE)
                    next_state = ST_RUN;
            end
            ST_RUN:  if (last_hs) next_state = ST_WAIT;
            default: next_state = ST_CFG;
        endcase
    end

    // Handshakes are masked during the reset cycle so an abandoned frame moves no data.
    always_comb begin
        O_BUSY         = (state == ST_RUN);
        F_O_DATA       = S_I_DATA;
        F_O_DATA_TLAST = tlast;
        F_O_DATA_VALID = O_BUSY && !I_RESET && S_I_DATA_VALID;
        S_O_DATA_READY = O_BUSY && !I_RESET && F_I_DATA_READY;
        F_O_CFG_VALID  = (state == ST_CFG) && cfg_pending && !I_RESET;
        F_O_CFG_DATA   = pack_cfg(nfft_l, fwd_inv_l);
        cfg_hs         = F_O_CFG_VALID && F_I_CFG_READY;
        data_hs        = F_O_DATA_VALID && F_I_DATA_READY;
        last_hs        = data_hs && tlast;
        cnt_clear      = (state == ST_WAIT) && (next_state == ST_RUN);
        // After reset the CFG state spends one cycle capturing the request before offering it.
        load_cfg       = ((state == ST_CFG) && !cfg_pending) ||
                         ((state == ST_WAIT) && (next_state == ST_CFG));
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            cfg_pending <= 1'b0;
            nfft_l      <= 4'(MIN_LOG2);
            fwd_inv_l   <= 1'b0;
            O_FRAME_CNT <= '0;
            O_ERR_TLAST <= 1'b0;
        end else begin
            if (load_cfg) begin
                nfft_l      <= req_nfft;
                fwd_inv_l   <= I_FWD_INV;
                cfg_pending <= 1'b1;
            end else if (cfg_hs) begin
                cfg_pending <= 1'b0;
            end
            if (last_hs)
                O_FRAME_CNT <= O_FRAME_CNT + 16'd1;
            if (data_hs && (S_I_DATA_TLAST != tlast))
                O_ERR_TLAST <= 1'b1;
        end
    end

`ifdef FFT_CTRL_EVENT_EN
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET)
            O_ERR_FFT <= 1'b0;
        else if (F_I_EV_TLAST_UNEXPECTED || F_I_EV_TLAST_MISSING)
            O_ERR_FFT <= 1'b1;
    end
`endif

    fft_frame_counter #(
        .MAX_LOG2(MAX_LOG2)
    ) u_counter (
        .clk       (I_CLOCK),
        .rst       (I_RESET),
        .clear     (cnt_clear),
        .advance   (data_hs),
        .nfft_log2 (nfft_l),
        .tlast     (tlast)
    );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: frame-level reference model checked every
// cycle on the falling edge, plus directed scenarios with literal expectations.
module tb_fft_frame_ctrl;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET = 1'b1;
    logic        I_ENABLE = 1'b0;
    logic [3:0]  I_NFFT_LOG2 = 4'd3;
    logic        I_FWD_INV = 1'b1;
    logic        S_I_DATA_VALID = 1'b0;
    logic        S_O_DATA_READY;
    logic [31:0] S_I_DATA = '0;
    logic        S_I_DATA_TLAST = 1'b0;
    logic        F_O_DATA_VALID;
    logic        F_I_DATA_READY = 1'b1;
    logic [31:0] F_O_DATA;
    logic        F_O_DATA_TLAST;
    logic        F_O_CFG_VALID;
    logic        F_I_CFG_READY = 1'b1;
    logic [15:0] F_O_CFG_DATA;
    logic [15:0] O_FRAME_CNT;
    logic        O_ERR_TLAST;
    logic        O_BUSY;
`ifdef FFT_CTRL_EVENT_EN
    logic        F_I_EV_TLAST_UNEXPECTED = 1'b0;
    logic        F_I_EV_TLAST_MISSING = 1'b0;
    logic        O_ERR_FFT;
`endif

    always #5 I_CLOCK = ~I_CLOCK;

    fft_frame_ctrl #(
        .DATA_W   (32),
        .MAX_LOG2 (10)
    ) dut (
        .I_CLOCK        (I_CLOCK),
        .I_RESET        (I_RESET),
        .I_ENABLE       (I_ENABLE),
        .I_NFFT_LOG2    (I_NFFT_LOG2),
        .I_FWD_INV      (I_FWD_INV),
        .S_I_DATA_VALID (S_I_DATA_VALID),
        .S_O_DATA_READY (S_O_DATA_READY),
        .S_I_DATA       (S_I_DATA),
        .S_I_DATA_TLAST (S_I_DATA_TLAST),
        .F_O_DATA_VALID (F_O_DATA_VALID),
        .F_I_DATA_READY (F_I_DATA_READY),
        .F_O_DATA       (F_O_DATA),
        .F_O_DATA_TLAST (F_O_DATA_TLAST),
        .F_O_CFG_VALID  (F_O_CFG_VALID),
        .F_I_CFG_READY  (F_I_CFG_READY),
        .F_O_CFG_DATA   (F_O_CFG_DATA),
        .O_FRAME_CNT    (O_FRAME_CNT),
        .O_ERR_TLAST    (O_ERR_TLAST),
`ifdef FFT_CTRL_EVENT_EN
        .F_I_EV_TLAST_UNEXPECTED (F_I_EV_TLAST_UNEXPECTED),
        .F_I_EV_TLAST_MISSING    (F_I_EV_TLAST_MISSING),
        .O_ERR_FFT               (O_ERR_FFT),
`endif
        .O_BUSY         (O_BUSY)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: frame length comes from the last accepted config.
    int m_len    = 8;
    int m_cnt    = 0;
    int m_frames = 0;
    int m_err    = 0;
    int cfg_cnt  = 0;
    int hs_total = 0;
    int obs_len  = 0;
    logic [15:0] last_cfg = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int clamp_req(input int n);
        if (n < 3) return 3;
        if (n > 10) return 10;
        return n;
    endfunction

    function automatic int model_cfg(input int n, input int fwd);
        return fwd * 256 + clamp_req(n);
    endfunction

    always @(negedge I_CLOCK) begin
        bit exp_tl;
        if (I_RESET) begin
            m_cnt    = 0;
            m_frames = 0;
            m_err    = 0;
        end else begin
            check("frame_cnt", 32'(O_FRAME_CNT), 32'(m_frames));
            check("err_tlast", 32'(O_ERR_TLAST), 32'(m_err));
            check("cfg_data_exclusive", 32'(F_O_CFG_VALID && (F_O_DATA_VALID || S_O_DATA_READY)), 32'd0);
            if (O_BUSY) begin
                check("pass_valid", 32'(F_O_DATA_VALID), 32'(S_I_DATA_VALID));
                check("pass_ready", 32'(S_O_DATA_READY), 32'(F_I_DATA_READY));
            end else begin
                check("idle_valid", 32'(F_O_DATA_VALID), 32'd0);
                check("idle_ready", 32'(S_O_DATA_READY), 32'd0);
            end
            if (F_O_CFG_VALID) begin
                check("cfg_word_model", 32'(F_O_CFG_DATA), 32'(model_cfg(int'(I_NFFT_LOG2), int'(I_FWD_INV))));
                if (F_I_CFG_READY) begin
                    cfg_cnt++;
                    last_cfg = F_O_CFG_DATA;
                    m_len    = 1 << clamp_req(int'(I_NFFT_LOG2));
                    m_cnt    = 0;
                end
            end
            if (F_O_DATA_VALID) begin
                exp_tl = (m_cnt == m_len - 1);
                check("data_pass", F_O_DATA, S_I_DATA);
                check("tlast_gen", 32'(F_O_DATA_TLAST), 32'(exp_tl));
                if (F_I_DATA_READY) begin
                    hs_total++;
                    if (S_I_DATA_TLAST != exp_tl) m_err = 1;
                    if (F_O_DATA_TLAST) obs_len = m_cnt + 1;
                    if (exp_tl) begin
                        m_frames = (m_frames + 1) % 65536;
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic wait_cfg(input logic [15:0] exp_word);
        int start;
        int budget;
        start  = cfg_cnt;
        budget = 60;
        while (cfg_cnt == start && budget > 0) begin
            @(posedge I_CLOCK); #1;
            budget--;
        end
        check("cfg_accept_in_time", 32'(budget > 0), 32'd1);
        check("cfg_word", 32'(last_cfg), 32'(exp_word));
    endtask

    task automatic send_frame(input int n, input bit stall, input int tl_at,
                              input int chg_at, input logic [3:0] chg_nfft, input int abort_at);
        int  i;
        int  budget;
        bit  hs;
        i       = 0;
        budget  = n * 8 + 64;
        obs_len = 0;
        I_ENABLE = 1'b1;
        S_I_DATA = $urandom;
        while (i < n && i != abort_at && budget > 0) begin
            if (i == chg_at) I_NFFT_LOG2 = chg_nfft;
            S_I_DATA_VALID = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            F_I_DATA_READY = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            S_I_DATA_TLAST = (i == tl_at);
            @(negedge I_CLOCK);
            hs = S_I_DATA_VALID && S_O_DATA_READY;
            @(posedge I_CLOCK); #1;
            if (hs) begin
                i++;
                S_I_DATA = $urandom;
            end
            budget--;
        end
        check("frame_in_time", 32'(budget > 0), 32'd1);
        S_I_DATA_VALID = 1'b0;
        S_I_DATA_TLAST = 1'b0;
        F_I_DATA_READY = 1'b1;
        I_ENABLE       = 1'b0;
    endtask

    initial begin
        int before_hs;
        int before_cfg;

        repeat (3) @(posedge I_CLOCK);
        #1;
        check("rst_cfg_valid", 32'(F_O_CFG_VALID), 32'd0);
        check("rst_data_valid", 32'(F_O_DATA_VALID), 32'd0);
        check("rst_busy", 32'(O_BUSY), 32'd0);
        check("rst_frame_cnt", 32'(O_FRAME_CNT), 32'd0);
        check("rst_err", 32'(O_ERR_TLAST), 32'd0);
`ifdef FFT_CTRL_EVENT_EN
        check("rst_err_fft", 32'(O_ERR_FFT), 32'd0);
`endif
        I_RESET = 1'b0;

        // 8-point forward frame
        wait_cfg(16'h0103);
        send_frame(8, 1'b0, 7, -1, 4'd0, -1);
        check("len_8", 32'(obs_len), 32'd8);
        check("cnt_after_first", 32'(O_FRAME_CNT), 32'd1);
        repeat (5) @(posedge I_CLOCK);
        #1;
        check("cfg_once", 32'(cfg_cnt), 32'd1);

        // clamping: above MAX_LOG2 and below MIN_LOG2
        I_NFFT_LOG2 = 4'd15;
        I_FWD_INV   = 1'b0;
        wait_cfg(16'h000A);
        send_frame(1024, 1'b0, 1023, -1, 4'd0, -1);
        check("len_1024", 32'(obs_len), 32'd1024);
        I_NFFT_LOG2 = 4'd1;
        wait_cfg(16'h0003);
        send_frame(8, 1'b0, 7, -1, 4'd0, -1);
        check("len_clamp_low", 32'(obs_len), 32'd8);

        // config change mid-frame takes effect only after the frame
        I_NFFT_LOG2 = 4'd4;
        I_FWD_INV   = 1'b1;
        wait_cfg(16'h0104);
        send_frame(16, 1'b0, 15, 6, 4'd5, -1);
        check("len_16_unchanged", 32'(obs_len), 32'd16);
        wait_cfg(16'h0105);
        send_frame(32, 1'b0, 31, -1, 4'd0, -1);
        check("len_32", 32'(obs_len), 32'd32);

        // random stalls on both sides
        send_frame(32, 1'b1, 31, -1, 4'd0, -1);
        check("len_32_stall_a", 32'(obs_len), 32'd32);
        send_frame(32, 1'b1, 31, -1, 4'd0, -1);
        check("len_32_stall_b", 32'(obs_len), 32'd32);

        // config held off for 20 cycles: no data may move
        F_I_CFG_READY  = 1'b0;
        I_NFFT_LOG2    = 4'd3;
        S_I_DATA_VALID = 1'b1;
        F_I_DATA_READY = 1'b1;
        before_hs  = hs_total;
        before_cfg = cfg_cnt;
        repeat (20) @(posedge I_CLOCK);
        #1;
        check("cfg_held_valid", 32'(F_O_CFG_VALID), 32'd1);
        check("no_data_in_cfg", 32'(hs_total - before_hs), 32'd0);
        check("no_cfg_accept", 32'(cfg_cnt - before_cfg), 32'd0);
        S_I_DATA_VALID = 1'b0;
        F_I_CFG_READY  = 1'b1;
        wait_cfg(16'h0103);

        // upstream TLAST on sample 5 of 8
        check("err_clear_before", 32'(O_ERR_TLAST), 32'd0);
        send_frame(8, 1'b0, 4, -1, 4'd0, -1);
        check("len_8_bad_tlast", 32'(obs_len), 32'd8);
        check("err_set", 32'(O_ERR_TLAST), 32'd1);
        send_frame(8, 1'b0, 7, -1, 4'd0, -1);
        check("err_sticky", 32'(O_ERR_TLAST), 32'd1);
        check("cnt_nine", 32'(O_FRAME_CNT), 32'd9);

        // reset in the middle of a frame
        before_cfg = cfg_cnt;
        send_frame(8, 1'b0, 7, -1, 4'd0, 3);
        I_RESET = 1'b1;
        @(posedge I_CLOCK); #1;
        check("mid_rst_cfg_valid", 32'(F_O_CFG_VALID), 32'd0);
        check("mid_rst_data_valid", 32'(F_O_DATA_VALID), 32'd0);
        check("mid_rst_ready", 32'(S_O_DATA_READY), 32'd0);
        check("mid_rst_tlast", 32'(F_O_DATA_TLAST), 32'd0);
        check("mid_rst_busy", 32'(O_BUSY), 32'd0);
        check("mid_rst_cnt", 32'(O_FRAME_CNT), 32'd0);
        check("mid_rst_err", 32'(O_ERR_TLAST), 32'd0);
        I_RESET = 1'b0;
        wait_cfg(16'h0103);
        check("cfg_reissued", 32'(cfg_cnt - before_cfg), 32'd1);
`ifdef FFT_CTRL_EVENT_EN
        check("err_fft_idle", 32'(O_ERR_FFT), 32'd0);
        F_I_EV_TLAST_MISSING = 1'b1;
        @(posedge I_CLOCK); #1;
        F_I_EV_TLAST_MISSING = 1'b0;
        repeat (3) @(posedge I_CLOCK);
        #1;
        check("err_fft_sticky", 32'(O_ERR_FFT), 32'd1);
`endif
        send_frame(8, 1'b0, 7, -1, 4'd0, -1);
        check("len_after_rst", 32'(obs_len), 32'd8);
        check("cnt_after_rst", 32'(O_FRAME_CNT), 32'd1);

        repeat (2) @(posedge I_CLOCK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
